// File: rtl/traffic_light_monitor_pkg.sv
// Shared types and helpers for the traffic light controller and its protocol monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    RED     = 2'b10,
    INVALID = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10
  } mon_state_t;

  localparam logic [2:0] LIGHTS_GREEN  = 3'b001;
  localparam logic [2:0] LIGHTS_YELLOW = 3'b010;
  localparam logic [2:0] LIGHTS_RED    = 3'b100;

  // The only legal successor of each phase; INVALID has no successor.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      GREEN:   next_phase = YELLOW;
      YELLOW:  next_phase = RED;
      RED:     next_phase = GREEN;
      default: next_phase = INVALID;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lights bus observed by the monitor plus the monitor's status outputs.
interface traffic_light_monitor_if #(
  parameter int TMR_W = 5,
  parameter int CNT_W = 8
);
  import traffic_pkg::*;

  logic [2:0]       lights_in;
  logic             enable;
  logic             clear_err;
  phase_t           phase_o;
  logic             phase_valid;
  logic [TMR_W-1:0] dwell_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic             err_illegal;
  logic             err_seq;
  logic             err_dwell;
  logic             any_err;

  modport master (
    output lights_in, enable, clear_err,
    input  phase_o, phase_valid, dwell_o, cycle_count_o,
           err_illegal, err_seq, err_dwell, any_err
  );

  modport slave (
    input  lights_in, enable, clear_err,
    output phase_o, phase_valid, dwell_o, cycle_count_o,
           err_illegal, err_seq, err_dwell, any_err
  );

endinterface

// File: rtl/traffic_light_monitor_decode.sv
// Combinational decode of the one-hot lights bus into a phase and a legality bit.
module traffic_lights_decode
  import traffic_pkg::*;
(
  input  logic [2:0] lights_i,
  output phase_t     phase_o,
  output logic       legal_o
);

  always_comb begin
    phase_o = INVALID;
    legal_o = 1'b0;
    case (lights_i)
      LIGHTS_GREEN:  begin phase_o = GREEN;  legal_o = 1'b1; end
      LIGHTS_YELLOW: begin phase_o = YELLOW; legal_o = 1'b1; end
      LIGHTS_RED:    begin phase_o = RED;    legal_o = 1'b1; end
      default:       begin phase_o = INVALID; legal_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light lights bus: phase order, dwell time and encoding.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int DWELL_CYCLES = 11,
  parameter int TMR_W        = 5,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  traffic_light_monitor_if.slave  mon
);

  localparam logic [TMR_W-1:0] DWELL_MAX = TMR_W'(DWELL_CYCLES);
  localparam logic [TMR_W-1:0] DWELL_SAT = {TMR_W{1'b1}};

  mon_state_t       state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [TMR_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             first_seg_q, first_seg_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_seq_q, err_seq_d;
  logic             err_dwell_q, err_dwell_d;
  logic             any_err_q;
  logic             set_illegal, set_seq, set_dwell;
  phase_t           dec_phase;
  logic             dec_legal;

  traffic_lights_decode u_decode (
    .lights_i (mon.lights_in),
    .phase_o  (dec_phase),
    .legal_o  (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= INVALID;
      dwell_q       <= '0;
      cycle_q       <= '0;
      first_seg_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      err_dwell_q   <= 1'b0;
      any_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      cycle_q       <= cycle_d;
      first_seg_q   <= first_seg_d;
      err_illegal_q <= err_illegal_d;
      err_seq_q     <= err_seq_d;
      err_dwell_q   <= err_dwell_d;
      any_err_q     <= err_illegal_d | err_seq_d | err_dwell_d;
    end
  end

  // The first segment after sync may be partial, so it is exempt from the underrun check.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    cycle_d     = cycle_q;
    first_seg_d = first_seg_q;
    set_illegal = 1'b0;
    set_seq     = 1'b0;
    set_dwell   = 1'b0;

    if (!mon.enable) begin
      state_d = IDLE;
      phase_d = INVALID;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
          phase_d = INVALID;
          dwell_d = '0;
        end
        SYNC: begin
          if (dec_legal) begin
            state_d     = TRACK;
            phase_d     = dec_phase;
            dwell_d     = TMR_W'(1);
            first_seg_d = 1'b1;
          end
        end
        TRACK: begin
          if (!dec_legal) begin
            set_illegal = 1'b1;
            state_d     = SYNC;
            phase_d     = INVALID;
            dwell_d     = '0;
          end else if (dec_phase == phase_q) begin
            if (dwell_q == DWELL_MAX) set_dwell = 1'b1;
            if (dwell_q != DWELL_SAT) dwell_d = dwell_q + TMR_W'(1);
          end else begin
            if (dec_phase != next_phase(phase_q)) set_seq = 1'b1;
            if (!first_seg_q && (dwell_q != DWELL_MAX)) set_dwell = 1'b1;
            if ((phase_q == RED) && (dec_phase == GREEN)) cycle_d = cycle_q + CNT_W'(1);
            phase_d     = dec_phase;
            dwell_d     = TMR_W'(1);
            first_seg_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = INVALID;
          dwell_d = '0;
        end
      endcase
    end

    err_illegal_d = set_illegal | (err_illegal_q & ~mon.clear_err);
    err_seq_d     = set_seq     | (err_seq_q     & ~mon.clear_err);
    err_dwell_d   = set_dwell   | (err_dwell_q   & ~mon.clear_err);
  end

  assign mon.phase_o       = phase_q;
  assign mon.phase_valid   = (phase_q != INVALID);
  assign mon.dwell_o       = dwell_q;
  assign mon.cycle_count_o = cycle_q;
  assign mon.err_illegal   = err_illegal_q;
  assign mon.err_seq       = err_seq_q;
  assign mon.err_dwell     = err_dwell_q;
  assign mon.any_err       = any_err_q;

endmodule
